// File: rtl/ram_arb_pkg.sv
// Shared definitions for the round-robin RAM controller: default geometry,
// sequencer state encoding and requester identifiers.
package ram_arb_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_ADDR_W = 4;
   localparam int DEF_DEPTH  = 16;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/ram_rr_controller_rr_arb2.sv
// Two-way round-robin arbiter with its own priority pointer; the pointer
// flips to the other requester after every grant.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] cand,
   output logic [1:0] gnt
);

   logic ptr;

   always_comb begin
      gnt = cand;
      if (cand == 2'b11) begin
         gnt = ptr ? 2'b10 : 2'b01;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= 1'b0;
      end else if (gnt[0]) begin
         ptr <= 1'b1;
      end else if (gnt[1]) begin
         ptr <= 1'b0;
      end
   end

endmodule

// File: rtl/ram_rr_controller.sv
// Sequencer/arbiter in front of a dual-port RAM: zero-sweeps the RAM after
// reset, then shares the write and read ports between two requesters.
module ram_rr_controller
   import ram_arb_pkg::*;
#(
   parameter int DATA_W  = ram_arb_pkg::DEF_DATA_W,
   parameter int ADDR_W  = ram_arb_pkg::DEF_ADDR_W,
   parameter int DEPTH   = ram_arb_pkg::DEF_DEPTH,
   parameter int INIT_EN = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              init_done,
   output logic              ram_wr_en,
   output logic [ADDR_W-1:0] ram_w_addr,
   output logic [DATA_W-1:0] ram_w_data,
   output logic              ram_rd_en,
   output logic [ADDR_W-1:0] ram_rd_addr,
   input  logic [DATA_W-1:0] ram_rd_data
);

   state_t            state;
   logic [ADDR_W-1:0] init_cnt;
   logic              run;
   logic [1:0]        wr_cand;
   logic [1:0]        rd_cand;
   logic [1:0]        wr_gnt;
   logic [1:0]        rd_gnt;
   logic              rd_valid_q;
   logic              rd_id_q;

   // Masking candidates outside RUN keeps both arbiters silent and their pointers frozen during INIT.
   assign run     = (state == ST_RUN);
   assign wr_cand = {req1 &  we1, req0 &  we0} & {2{run}};
   assign rd_cand = {req1 & ~we1, req0 & ~we0} & {2{run}};

   rr_arb2 u_wr_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .cand  (wr_cand),
      .gnt   (wr_gnt)
   );

   rr_arb2 u_rd_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .cand  (rd_cand),
      .gnt   (rd_gnt)
   );

   assign gnt0 = wr_gnt[0] | rd_gnt[0];
   assign gnt1 = wr_gnt[1] | rd_gnt[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
         init_cnt  <= '0;
         init_done <= 1'b0;
      end else begin
         case (state)
            ST_INIT: begin
               init_cnt <= init_cnt + 1'b1;
               if (init_cnt == ADDR_W'(DEPTH - 1)) begin
                  state     <= ST_RUN;
                  init_done <= 1'b1;
               end
            end
            ST_RUN: begin
               init_done <= 1'b1;
            end
            default: begin
               state <= ST_INIT;
            end
         endcase
      end
   end

   // The RAM answers one cycle after rd_en, so remember who asked.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid_q <= 1'b0;
         rd_id_q    <= REQ0;
      end else begin
         rd_valid_q <= |rd_gnt;
         rd_id_q    <= rd_gnt[1] ? REQ1 : REQ0;
      end
   end

   assign rvalid0 = rd_valid_q & (rd_id_q == REQ0);
   assign rvalid1 = rd_valid_q & (rd_id_q == REQ1);
   assign rdata0  = rvalid0 ? ram_rd_data : '0;
   assign rdata1  = rvalid1 ? ram_rd_data : '0;

   always_comb begin
      ram_wr_en   = 1'b0;
      ram_w_addr  = '0;
      ram_w_data  = '0;
      ram_rd_en   = 1'b0;
      ram_rd_addr = '0;
      if (state == ST_INIT) begin
         ram_wr_en  = 1'b1;
         ram_w_addr = init_cnt;
      end else begin
         if (wr_gnt[0]) begin
            ram_wr_en  = 1'b1;
            ram_w_addr = addr0;
            ram_w_data = wdata0;
         end else if (wr_gnt[1]) begin
            ram_wr_en  = 1'b1;
            ram_w_addr = addr1;
            ram_w_data = wdata1;
         end
         if (rd_gnt[0]) begin
            ram_rd_en   = 1'b1;
            ram_rd_addr = addr0;
         end else if (rd_gnt[1]) begin
            ram_rd_en   = 1'b1;
            ram_rd_addr = addr1;
         end
      end
   end

endmodule

// File: tb/tb_ram_rr_controller.sv
// Self-checking bench for ram_rr_controller: a behavioural RAM plus a
// cycle-level reference model of sweep, round-robin grants and read returns.
module tb_ram_rr_controller;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req0, req1, we0, we1;
   logic [3:0] addr0, addr1;
   logic [7:0] wdata0, wdata1;
   logic       gnt0, gnt1, rvalid0, rvalid1, init_done;
   logic [7:0] rdata0, rdata1;
   logic       ram_wr_en, ram_rd_en;
   logic [3:0] ram_w_addr, ram_rd_addr;
   logic [7:0] ram_w_data, ram_rd_data;

   logic [7:0] ramMem [16];

   int         checkCnt = 0;
   int         failCnt  = 0;

   bit         mInit;
   int         mCnt;
   bit         mInitDone;
   int         mPtrW, mPtrR;
   logic [7:0] refMem [16];
   bit         mRv [2];
   logic [7:0] mRd [2];
   bit         lastGnt [2];

   always #5 clk = ~clk;

   ram_rr_controller dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req0        (req0),
      .req1        (req1),
      .we0         (we0),
      .we1         (we1),
      .addr0       (addr0),
      .addr1       (addr1),
      .wdata0      (wdata0),
      .wdata1      (wdata1),
      .gnt0        (gnt0),
      .gnt1        (gnt1),
      .rvalid0     (rvalid0),
      .rvalid1     (rvalid1),
      .rdata0      (rdata0),
      .rdata1      (rdata1),
      .init_done   (init_done),
      .ram_wr_en   (ram_wr_en),
      .ram_w_addr  (ram_w_addr),
      .ram_w_data  (ram_w_data),
      .ram_rd_en   (ram_rd_en),
      .ram_rd_addr (ram_rd_addr),
      .ram_rd_data (ram_rd_data)
   );

   // Dual-port RAM with registered read; NBA ordering gives read-before-write.
   always @(posedge clk) begin
      if (ram_wr_en) ramMem[ram_w_addr] <= ram_w_data;
      if (ram_rd_en) ram_rd_data <= ramMem[ram_rd_addr];
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCnt++;
      if (got !== exp) begin
         failCnt++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int pick(input bit c0, input bit c1, input int ptr);
      if (c0 && c1) return ptr;
      if (c0) return 0;
      if (c1) return 1;
      return -1;
   endfunction

   task automatic modelReset();
      mInit      = 1'b1;
      mCnt       = 0;
      mInitDone  = 1'b0;
      mPtrW      = 0;
      mPtrR      = 0;
      mRv[0]     = 1'b0;
      mRv[1]     = 1'b0;
      lastGnt[0] = 1'b0;
      lastGnt[1] = 1'b0;
   endtask

   // Drives one cycle of requests, checks every output against the model, then advances one clock.
   task automatic applyStimulus(input bit r0, input bit w0, input logic [3:0] a0, input logic [7:0] d0,
                                input bit r1, input bit w1, input logic [3:0] a1, input logic [7:0] d1);
      logic [3:0] addrs [2];
      logic [7:0] datas [2];
      int         wWin, rWin;
      bit         eG [2];
      bit         eWe, eRe;
      logic [3:0] eWa, eRa;
      logic [7:0] eWd;
      req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
      req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
      addrs[0] = a0; addrs[1] = a1;
      datas[0] = d0; datas[1] = d1;
      #1;
      wWin = -1; rWin = -1;
      eWe = 1'b0; eRe = 1'b0; eWa = '0; eRa = '0; eWd = '0;
      if (mInit) begin
         eWe = 1'b1;
         eWa = 4'(mCnt);
      end else begin
         wWin = pick(r0 && w0, r1 && w1, mPtrW);
         rWin = pick(r0 && !w0, r1 && !w1, mPtrR);
         if (wWin >= 0) begin
            eWe = 1'b1; eWa = addrs[wWin]; eWd = datas[wWin];
         end
         if (rWin >= 0) begin
            eRe = 1'b1; eRa = addrs[rWin];
         end
      end
      eG[0] = (wWin == 0) || (rWin == 0);
      eG[1] = (wWin == 1) || (rWin == 1);

      checkOutput("gnt0", gnt0, eG[0]);
      checkOutput("gnt1", gnt1, eG[1]);
      checkOutput("ram_wr_en", ram_wr_en, eWe);
      checkOutput("ram_w_addr", ram_w_addr, eWa);
      checkOutput("ram_w_data", ram_w_data, eWd);
      checkOutput("ram_rd_en", ram_rd_en, eRe);
      checkOutput("ram_rd_addr", ram_rd_addr, eRa);
      checkOutput("rvalid0", rvalid0, mRv[0]);
      checkOutput("rvalid1", rvalid1, mRv[1]);
      checkOutput("rdata0", rdata0, mRv[0] ? mRd[0] : 8'h00);
      checkOutput("rdata1", rdata1, mRv[1] ? mRd[1] : 8'h00);
      checkOutput("init_done", init_done, mInitDone);

      lastGnt[0] = eG[0];
      lastGnt[1] = eG[1];
      for (int i = 0; i < 2; i++) begin
         mRv[i] = (rWin == i);
         if (rWin == i) mRd[i] = refMem[addrs[i]];
      end
      if (eWe) refMem[eWa] = eWd;
      if (wWin >= 0) mPtrW = 1 - wWin;
      if (rWin >= 0) mPtrR = 1 - rWin;
      if (mInit) begin
         if (mCnt == 15) begin
            mInit     = 1'b0;
            mInitDone = 1'b1;
         end
         mCnt++;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00);
   endtask

   initial begin
      bit         p0, p1, pw0, pw1;
      logic [3:0] pa0, pa1;
      logic [7:0] pd0, pd1;

      req0 = 1'b1; we0 = 1'b1; addr0 = 4'd7; wdata0 = 8'hFF;
      req1 = 1'b1; we1 = 1'b0; addr1 = 4'd2; wdata1 = 8'h00;
      modelReset();
      repeat (2) @(negedge clk);
      checkOutput("reset_gnt0", gnt0, 1'b0);
      checkOutput("reset_gnt1", gnt1, 1'b0);
      checkOutput("reset_rvalid0", rvalid0, 1'b0);
      checkOutput("reset_rvalid1", rvalid1, 1'b0);
      checkOutput("reset_init_done", init_done, 1'b0);
      rst_n = 1'b1;

      // Zero sweep, then first RUN cycle confirms init_done.
      idleCycles(17);

      // Write then read back from requester 0.
      applyStimulus(1, 1, 4'd3, 8'hA5, 0, 0, 4'd0, 8'h00);
      applyStimulus(1, 0, 4'd3, 8'h00, 0, 0, 4'd0, 8'h00);
      idleCycles(1);

      // Lone requester-1 write hands write priority back to requester 0 before the contention run.
      applyStimulus(0, 0, 4'd0, 8'h00, 1, 1, 4'd1, 8'h11);
      for (int i = 0; i < 6; i++) applyStimulus(1, 1, 4'd1, 8'(i), 1, 1, 4'd2, 8'(8'h80 + i));

      // Same-address write and read in one cycle returns old content.
      applyStimulus(1, 1, 4'd5, 8'h3C, 1, 0, 4'd5, 8'h00);
      idleCycles(1);
      applyStimulus(0, 0, 4'd0, 8'h00, 1, 0, 4'd5, 8'h00);
      idleCycles(1);

      for (int i = 0; i < 6; i++) applyStimulus(1, 0, 4'd3, 8'h00, 1, 0, 4'd5, 8'h00);
      idleCycles(1);

      // Reset right after a read grant must swallow the pending read data.
      req0 = 1'b1; we0 = 1'b0; addr0 = 4'd3; req1 = 1'b0; we1 = 1'b0;
      #1;
      checkOutput("rst_mid_gnt0_before", gnt0, 1'b1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_mid_rvalid0", rvalid0, 1'b0);
      checkOutput("rst_mid_rdata0", rdata0, 8'h00);
      checkOutput("rst_mid_gnt0", gnt0, 1'b0);
      checkOutput("rst_mid_init_done", init_done, 1'b0);
      modelReset();
      @(negedge clk);
      @(negedge clk);
      checkOutput("rst_hold_rvalid0", rvalid0, 1'b0);
      rst_n = 1'b1;
      idleCycles(17);
      applyStimulus(1, 0, 4'd3, 8'h00, 0, 0, 4'd0, 8'h00);
      idleCycles(1);

      // Random traffic on a narrow address range to provoke collisions; requests held until granted.
      p0 = 1'b0; p1 = 1'b0;
      pw0 = 1'b0; pw1 = 1'b0; pa0 = '0; pa1 = '0; pd0 = '0; pd1 = '0;
      for (int c = 0; c < 400; c++) begin
         if (!p0 && $urandom_range(0, 2) != 0) begin
            p0 = 1'b1; pw0 = 1'($urandom_range(0, 1));
            pa0 = 4'($urandom_range(0, 3)); pd0 = 8'($urandom);
         end
         if (!p1 && $urandom_range(0, 2) != 0) begin
            p1 = 1'b1; pw1 = 1'($urandom_range(0, 1));
            pa1 = 4'($urandom_range(0, 3)); pd1 = 8'($urandom);
         end
         applyStimulus(p0, pw0, pa0, pd0, p1, pw1, pa1, pd1);
         if (lastGnt[0]) p0 = 1'b0;
         if (lastGnt[1]) p1 = 1'b0;
      end
      idleCycles(2);

      $display("End of test - %0d assertions evaluated, %0d failures", checkCnt, failCnt);
      $finish;
   end

endmodule
